// File: rtl/den_gt_countdown.sv
// rtl/den_gt_countdown.sv - per-route BCD countdown and seven-segment display for the traffic light controller
module den_gt_countdown #(
    parameter int TICK_DIV = 50000000,
    parameter int T_GREEN  = 3,
    parameter int T_YELLOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] light,
    output logic [7:0] cnt_a_bcd,
    output logic [7:0] cnt_b_bcd,
    output logic [6:0] seg_a1,
    output logic [6:0] seg_a0,
    output logic [6:0] seg_b1,
    output logic [6:0] seg_b0,
    output logic       valid,
    output logic       err
);

    localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int T_RED = T_GREEN + T_YELLOW;

    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    // Reload constants, already split into {tens,units} BCD
    localparam logic [7:0] BCD_G = {4'(T_GREEN / 10),  4'(T_GREEN % 10)};
    localparam logic [7:0] BCD_Y = {4'(T_YELLOW / 10), 4'(T_YELLOW % 10)};
    localparam logic [7:0] BCD_R = {4'(T_RED / 10),    4'(T_RED % 10)};

    // Light patterns, bit order {g1,y1,r1,g2,y2,r2}
    localparam logic [5:0] P_IDLE  = 6'b010010;
    localparam logic [5:0] P_GA_RB = 6'b100001;
    localparam logic [5:0] P_YA_RB = 6'b010001;
    localparam logic [5:0] P_RA_GB = 6'b001100;
    localparam logic [5:0] P_RA_YB = 6'b001010;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [5:0]    light_q;
    logic [5:0]    light_d;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          running;
    logic          illegal;
    logic          chg_a;
    logic          chg_b;
    logic [7:0]    cnt_a_nx;
    logic [7:0]    cnt_b_nx;

    // Reload value for one route's {g,y,r} triple
    function automatic logic [7:0] reload_val(input logic [2:0] l);
        case (l)
            3'b100:  reload_val = BCD_G;
            3'b010:  reload_val = BCD_Y;
            3'b001:  reload_val = BCD_R;
            default: reload_val = 8'h00;
        endcase
    endfunction

    // Two-digit BCD decrement that stops at zero
    function automatic logic [7:0] bcd_dec(input logic [7:0] c);
        if (c == 8'h00) begin
            bcd_dec = 8'h00;
        end else if (c[3:0] == 4'd0) begin
            bcd_dec = {c[7:4] - 4'd1, 4'd9};
        end else begin
            bcd_dec = {c[7:4], c[3:0] - 4'd1};
        end
    endfunction

    // Active-low {g,f,e,d,c,b,a} digit decode; non-BCD codes blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Classify the registered pattern and detect per-route light changes
    always_comb begin
        running = (light_q == P_GA_RB) || (light_q == P_YA_RB) ||
                  (light_q == P_RA_GB) || (light_q == P_RA_YB);
        illegal = !running && (light_q != P_IDLE);
        chg_a   = (light_q[5:3] != light_d[5:3]);
        chg_b   = (light_q[2:0] != light_d[2:0]);
        tick    = (div_cnt == DIV_LAST);
    end

    // Counter next state: force to zero, else reload on change, else count down on tick
    always_comb begin
        cnt_a_nx = cnt_a_bcd;
        cnt_b_nx = cnt_b_bcd;
        if (!running) begin
            cnt_a_nx = 8'h00;
            cnt_b_nx = 8'h00;
        end else begin
            if (chg_a) begin
                cnt_a_nx = reload_val(light_q[5:3]);
            end else if (tick) begin
                cnt_a_nx = bcd_dec(cnt_a_bcd);
            end
            if (chg_b) begin
                cnt_b_nx = reload_val(light_q[2:0]);
            end else if (tick) begin
                cnt_b_nx = bcd_dec(cnt_b_bcd);
            end
        end
    end

    // Input pipeline, tick divider, counters and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            light_q   <= P_IDLE;
            light_d   <= P_IDLE;
            div_cnt   <= '0;
            cnt_a_bcd <= 8'h00;
            cnt_b_bcd <= 8'h00;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            light_q   <= light;
            light_d   <= light_q;
            div_cnt   <= tick ? '0 : div_cnt + DW'(1);
            cnt_a_bcd <= cnt_a_nx;
            cnt_b_bcd <= cnt_b_nx;
            valid     <= running;
            err       <= err | illegal;
        end
    end

    // Display registers: blank everything unless running, blank a leading zero tens digit
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_a1 <= SEG_BLANK;
            seg_a0 <= SEG_BLANK;
            seg_b1 <= SEG_BLANK;
            seg_b0 <= SEG_BLANK;
        end else begin
            seg_a1 <= (valid && cnt_a_bcd[7:4] != 4'd0) ? seg7(cnt_a_bcd[7:4]) : SEG_BLANK;
            seg_a0 <= valid ? seg7(cnt_a_bcd[3:0]) : SEG_BLANK;
            seg_b1 <= (valid && cnt_b_bcd[7:4] != 4'd0) ? seg7(cnt_b_bcd[7:4]) : SEG_BLANK;
            seg_b0 <= valid ? seg7(cnt_b_bcd[3:0]) : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_den_gt_countdown.sv
// tb/tb_den_gt_countdown.sv - scoreboard bench for den_gt_countdown
module tb_den_gt_countdown;

    typedef struct {
        int         at;
        bit         segs;
        logic [7:0] a;
        logic [7:0] b;
        logic       v;
        logic       e;
        logic [6:0] sa1;
        logic [6:0] sa0;
        logic [6:0] sb1;
        logic [6:0] sb0;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] light = 6'b010010;

    logic [7:0] u0_cnt_a, u0_cnt_b, u1_cnt_a, u1_cnt_b;
    logic [6:0] u0_sa1, u0_sa0, u0_sb1, u0_sb0;
    logic [6:0] u1_sa1, u1_sa0, u1_sb1, u1_sb0;
    logic       u0_valid, u0_err, u1_valid, u1_err;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mx;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base;
    int   base2;
    bit   done = 0;
    bit   flushed = 0;

    den_gt_countdown #(.TICK_DIV(3), .T_GREEN(3), .T_YELLOW(2)) u0 (
        .clk(clk), .reset(reset), .light(light),
        .cnt_a_bcd(u0_cnt_a), .cnt_b_bcd(u0_cnt_b),
        .seg_a1(u0_sa1), .seg_a0(u0_sa0), .seg_b1(u0_sb1), .seg_b0(u0_sb0),
        .valid(u0_valid), .err(u0_err)
    );

    den_gt_countdown #(.TICK_DIV(3), .T_GREEN(9), .T_YELLOW(3)) u1 (
        .clk(clk), .reset(reset), .light(light),
        .cnt_a_bcd(u1_cnt_a), .cnt_b_bcd(u1_cnt_b),
        .seg_a1(u1_sa1), .seg_a0(u1_sa0), .seg_b1(u1_sb1), .seg_b0(u1_sb0),
        .valid(u1_valid), .err(u1_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_x(input int inst, input exp_t x);
        if (inst == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic pc(input int inst, input int at, input logic [7:0] a, input logic [7:0] b,
                      input logic v, input logic e);
        exp_t x;
        x.at = at; x.segs = 1'b0; x.a = a; x.b = b; x.v = v; x.e = e;
        x.sa1 = '0; x.sa0 = '0; x.sb1 = '0; x.sb0 = '0;
        push_x(inst, x);
    endtask

    task automatic ps(input int inst, input int at, input logic [6:0] sa1, input logic [6:0] sa0,
                      input logic [6:0] sb1, input logic [6:0] sb0);
        exp_t x;
        x.at = at; x.segs = 1'b1; x.a = '0; x.b = '0; x.v = 1'b0; x.e = 1'b0;
        x.sa1 = sa1; x.sa0 = sa0; x.sb1 = sb1; x.sb0 = sb0;
        push_x(inst, x);
    endtask

    task automatic compare(input int inst, input exp_t x);
        logic [7:0] ca, cb;
        logic       v, e;
        logic [6:0] s1, s0, t1, t0;
        if (inst == 0) begin
            ca = u0_cnt_a; cb = u0_cnt_b; v = u0_valid; e = u0_err;
            s1 = u0_sa1; s0 = u0_sa0; t1 = u0_sb1; t0 = u0_sb0;
        end else begin
            ca = u1_cnt_a; cb = u1_cnt_b; v = u1_valid; e = u1_err;
            s1 = u1_sa1; s0 = u1_sa0; t1 = u1_sb1; t0 = u1_sb0;
        end
        checks++;
        if (x.at != cyc) begin
            failures++;
            $display("FAIL missed_slot inst=%0d expected_cycle=%0d actual_cycle=%0d", inst, x.at, cyc);
        end else if (x.segs) begin
            if ({s1, s0, t1, t0} !== {x.sa1, x.sa0, x.sb1, x.sb0}) begin
                failures++;
                $display("FAIL segs inst=%0d cycle=%0d actual a1=%h a0=%h b1=%h b0=%h required a1=%h a0=%h b1=%h b0=%h",
                         inst, cyc, s1, s0, t1, t0, x.sa1, x.sa0, x.sb1, x.sb0);
            end
        end else begin
            if ({ca, cb, v, e} !== {x.a, x.b, x.v, x.e}) begin
                failures++;
                $display("FAIL cnt inst=%0d cycle=%0d actual a=%h b=%h valid=%b err=%b required a=%h b=%h valid=%b err=%b",
                         inst, cyc, ca, cb, v, e, x.a, x.b, x.v, x.e);
            end
        end
    endtask

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].at <= cyc) begin
            mx = q0.pop_front();
            compare(0, mx);
        end
        while (q1.size() > 0 && q1[0].at <= cyc) begin
            mx = q1.pop_front();
            compare(1, mx);
        end
        if (done && !flushed) begin
            if (q0.size() + q1.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL leftover actual=%0d pending required=0", q0.size() + q1.size());
            end
            flushed = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            pc(i, cyc, 8'h00, 8'h00, 1'b0, 1'b0);
            ps(i, cyc, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        end
        step();

        reset = 1'b1;
        light = 6'b100001;
        base  = cyc;

        pc(0, base + 2,  8'h03, 8'h05, 1'b1, 1'b0);
        pc(0, base + 3,  8'h02, 8'h04, 1'b1, 1'b0);
        ps(0, base + 3,  7'h7F, 7'h30, 7'h7F, 7'h12);
        ps(0, base + 4,  7'h7F, 7'h24, 7'h7F, 7'h19);
        pc(0, base + 5,  8'h02, 8'h04, 1'b1, 1'b0);
        pc(0, base + 6,  8'h01, 8'h03, 1'b1, 1'b0);
        pc(0, base + 9,  8'h00, 8'h02, 1'b1, 1'b0);
        pc(0, base + 12, 8'h00, 8'h01, 1'b1, 1'b0);
        pc(0, base + 15, 8'h00, 8'h00, 1'b1, 1'b0);
        pc(0, base + 18, 8'h00, 8'h00, 1'b0, 1'b0);
        ps(0, base + 19, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        pc(0, base + 21, 8'h03, 8'h05, 1'b1, 1'b0);
        pc(0, base + 24, 8'h02, 8'h04, 1'b1, 1'b0);
        pc(0, base + 26, 8'h02, 8'h04, 1'b1, 1'b0);
        pc(0, base + 27, 8'h01, 8'h03, 1'b1, 1'b0);
        pc(0, base + 29, 8'h05, 8'h03, 1'b1, 1'b0);
        pc(0, base + 30, 8'h04, 8'h02, 1'b1, 1'b0);
        ps(0, base + 30, 7'h7F, 7'h12, 7'h7F, 7'h30);
        pc(0, base + 32, 8'h00, 8'h00, 1'b0, 1'b1);
        ps(0, base + 33, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        pc(0, base + 34, 8'h00, 8'h00, 1'b0, 1'b1);
        pc(0, base + 36, 8'h03, 8'h05, 1'b1, 1'b1);
        pc(0, base + 39, 8'h02, 8'h04, 1'b1, 1'b1);
        pc(0, base + 41, 8'h00, 8'h00, 1'b0, 1'b0);
        ps(0, base + 41, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        pc(1, base + 2,  8'h09, 8'h12, 1'b1, 1'b0);
        pc(1, base + 3,  8'h08, 8'h11, 1'b1, 1'b0);
        ps(1, base + 3,  7'h7F, 7'h10, 7'h79, 7'h24);
        pc(1, base + 6,  8'h07, 8'h10, 1'b1, 1'b0);
        ps(1, base + 7,  7'h7F, 7'h78, 7'h79, 7'h40);
        pc(1, base + 9,  8'h06, 8'h09, 1'b1, 1'b0);
        ps(1, base + 10, 7'h7F, 7'h02, 7'h7F, 7'h10);

        goto(base + 16); light = 6'b010010;
        goto(base + 19); light = 6'b100001;
        goto(base + 24); light = 6'b010001;
        goto(base + 27); light = 6'b001100;
        goto(base + 30); light = 6'b110001;
        goto(base + 32); light = 6'b010010;
        goto(base + 34); light = 6'b100001;
        goto(base + 40); reset = 1'b0;
        goto(base + 42); reset = 1'b1;

        base2 = cyc;
        pc(0, base2 + 2, 8'h03, 8'h05, 1'b1, 1'b0);
        pc(0, base2 + 3, 8'h02, 8'h04, 1'b1, 1'b0);
        goto(base2 + 6);

        done = 1'b1;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
